i2c_target: RTL and testbench

I2C target (responder) with a 16-byte register file. It is the bus-side counterpart of `I2CMaster`: it lets the I2C master on `i2c0` be exercised in simulation and on the board, and it can emulate a simple peripheral such as an RTC register map. It sits directly on the open-drain `i2c0_scl`/`i2c0_sda` nets in `AudioWake`, with a local port that lets host logic observe the registers.

---
 rtl/i2c_target.sv | 202 ++++++++++++++++++++
 tb/tb_i2c_target.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target with a 16x8 register file: pointer byte, then write data or read data with auto-increment.
// Host side reads the registers combinationally and sees each I2C write as a one-cycle pulse.
module i2c_target #(
  parameter logic [6:0] ADDRESS = 7'h51
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sclIn,
  input  logic       sdaIn,
  output logic       sclOut,
  output logic       sdaOut,
  input  logic [3:0] hostAddr,
  output logic [7:0] hostData,
  output logic       wrValid,
  output logic [3:0] wrAddr,
  output logic [7:0] wrData,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
  } state_t;

  logic       scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_prev_q, scl_prev_d;
  logic       sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_prev_q, sda_prev_d;
  state_t     state_q, state_d;
  logic [7:0] shifter_q, shifter_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] ptr_q, ptr_d;
  logic [7:0] regs_q [16];
  logic [7:0] regs_d [16];
  logic       sda_out_q, sda_out_d;
  logic       wr_valid_q, wr_valid_d;
  logic [3:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       busy_q, busy_d;

  logic       scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0] shift_in;
  logic [3:0] ptr_inc;

  assign scl_rise = scl_s2_q & ~scl_prev_q;
  assign scl_fall = ~scl_s2_q & scl_prev_q;
  assign start_ev = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
  assign stop_ev  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
  assign shift_in = {shifter_q[6:0], sda_s2_q};
  assign ptr_inc  = ptr_q + 4'd1;

  always_comb begin
    scl_s1_d   = sclIn;
    scl_s2_d   = scl_s1_q;
    scl_prev_d = scl_s2_q;
    sda_s1_d   = sdaIn;
    sda_s2_d   = sda_s1_q;
    sda_prev_d = sda_s2_q;
    state_d    = state_q;
    shifter_d  = shifter_q;
    bit_cnt_d  = bit_cnt_q;
    ptr_d      = ptr_q;
    regs_d     = regs_q;
    sda_out_d  = sda_out_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;

    if (stop_ev) begin
      state_d   = IDLE;
      sda_out_d = 1'b1;
      busy_d    = 1'b0;
    end else if (start_ev) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_out_d = 1'b1;
    end else begin
      unique case (state_q)
        ADDR: if (scl_rise) begin
          shifter_d = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (shift_in[7:1] == ADDRESS) begin
              state_d = ADDR_ACK;
              busy_d  = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        // ACK phase: first SCL fall pulls SDA low, the fall ending the ACK clock moves on
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
          if (sda_out_q) begin
            sda_out_d = 1'b0;
          end else begin
            sda_out_d = 1'b1;
            bit_cnt_d = '0;
            if (state_q == ADDR_ACK) begin
              if (shifter_q[0]) begin
                state_d   = RDATA;
                shifter_d = regs_q[ptr_q];
                sda_out_d = regs_q[ptr_q][7];
              end else begin
                state_d = PTR;
              end
            end else begin
              state_d = WDATA;
            end
          end
        end
        PTR: if (scl_rise) begin
          shifter_d = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ptr_d   = shift_in[3:0];
            state_d = PTR_ACK;
          end
        end
        WDATA: if (scl_rise) begin
          shifter_d = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            regs_d[ptr_q] = shift_in;
            wr_valid_d    = 1'b1;
            wr_addr_d     = ptr_q;
            wr_data_d     = shift_in;
            ptr_d         = ptr_inc;
            state_d       = WDATA_ACK;
          end
        end
        RDATA: begin
          if (scl_fall) sda_out_d = shifter_q[7];
          if (scl_rise) begin
            shifter_d = {shifter_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = RACK;
          end
        end
        RACK: begin
          if (scl_fall) sda_out_d = 1'b1;
          if (scl_rise) begin
            ptr_d = ptr_inc;
            if (!sda_s2_q) begin
              shifter_d = regs_q[ptr_inc];
              bit_cnt_d = '0;
              state_d   = RDATA;
            end else begin
              sda_out_d = 1'b1;
              state_d   = IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      shifter_q  <= '0;
      bit_cnt_q  <= '0;
      ptr_q      <= '0;
      for (int unsigned i = 0; i < 16; i++) regs_q[i] <= '0;
      sda_out_q  <= 1'b1;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      scl_s1_q   <= scl_s1_d;
      scl_s2_q   <= scl_s2_d;
      scl_prev_q <= scl_prev_d;
      sda_s1_q   <= sda_s1_d;
      sda_s2_q   <= sda_s2_d;
      sda_prev_q <= sda_prev_d;
      state_q    <= state_d;
      shifter_q  <= shifter_d;
      bit_cnt_q  <= bit_cnt_d;
      ptr_q      <= ptr_d;
      regs_q     <= regs_d;
      sda_out_q  <= sda_out_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
    end
  end

  assign sclOut   = 1'b1;
  assign sdaOut   = sda_out_q;
  assign hostData = regs_q[hostAddr];
  assign wrValid  = wr_valid_q;
  assign wrAddr   = wr_addr_q;
  assign wrData   = wr_data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bus-master tasks drive an open-drain bus model,
// expected writes and read bytes are queued when driven and checked when observed.
module tb_i2c_target;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sclIn, sdaIn, sclOut, sdaOut;
  logic [3:0] hostAddr = '0;
  logic [7:0] hostData;
  logic       wrValid;
  logic [3:0] wrAddr;
  logic [7:0] wrData;
  logic       busy;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [3:0] a; logic [7:0] d; } wr_t;
  wr_t        wr_q[$];
  logic [7:0] rd_q[$];
  logic       wr_prev = 1'b0;

  assign sclIn = scl_m & sclOut;
  assign sdaIn = sda_m & sdaOut;

  always #5 clock = ~clock;

  i2c_target #(.ADDRESS(7'h51)) dut (
    .clock(clock), .reset(reset), .sclIn(sclIn), .sdaIn(sdaIn),
    .sclOut(sclOut), .sdaOut(sdaOut), .hostAddr(hostAddr), .hostData(hostData),
    .wrValid(wrValid), .wrAddr(wrAddr), .wrData(wrData), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (wrValid) begin
      wr_t e;
      chk("wr_pulse_width", {31'd0, wr_prev}, 0);
      chk("wr_expected", {31'd0, wr_q.size() > 0}, 1);
      if (wr_q.size() > 0) begin
        e = wr_q.pop_front();
        chk("wr_addr", {28'd0, wrAddr}, {28'd0, e.a});
        chk("wr_data", {24'd0, wrData}, {24'd0, e.d});
      end
    end
    wr_prev = wrValid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; clk(6);
    scl_m = 1'b1; clk(8);
    sda_m = 1'b0; clk(8);
    scl_m = 1'b0; clk(4);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; clk(4);
    scl_m = 1'b1; clk(8);
    sda_m = 1'b1; clk(8);
  endtask

  task automatic send_bit(input logic b, output logic s);
    sda_m = b;    clk(4);
    scl_m = 1'b1; clk(4);
    s = sdaIn;    clk(4);
    scl_m = 1'b0; clk(4);
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack_line);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    ack_line = s;
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] v);
    logic s;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, s);
      v = {v[6:0], s};
    end
    send_bit(nack, s);
  endtask

  task automatic wr_acked(input logic [7:0] b, input string tag);
    logic a;
    wbyte(b, a);
    chk(tag, {31'd0, a}, 0);
  endtask

  task automatic rd_check(input logic nack, input string tag);
    logic [7:0] v;
    rbyte(nack, v);
    chk(tag, {24'd0, v}, {24'd0, rd_q.pop_front()});
  endtask

  task automatic host_check(input logic [3:0] a, input logic [7:0] exp, input string tag);
    hostAddr = a;
    #1;
    chk(tag, {24'd0, hostData}, {24'd0, exp});
  endtask

  initial begin
    logic a;
    clk(4);
    chk("rst_sdaOut", {31'd0, sdaOut}, 1);
    chk("rst_sclOut", {31'd0, sclOut}, 1);
    chk("rst_wrValid", {31'd0, wrValid}, 0);
    chk("rst_wrAddr", {28'd0, wrAddr}, 0);
    chk("rst_wrData", {24'd0, wrData}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    host_check(4'd3, 8'h00, "rst_reg3");
    reset = 1'b0;
    clk(4);

    // write 51 W, ptr 03, A5 5A
    bus_start();
    wr_acked(8'hA2, "w1_addr_ack");
    chk("w1_busy", {31'd0, busy}, 1);
    wr_acked(8'h03, "w1_ptr_ack");
    wr_q.push_back('{4'd3, 8'hA5});
    wr_acked(8'hA5, "w1_d0_ack");
    wr_q.push_back('{4'd4, 8'h5A});
    wr_acked(8'h5A, "w1_d1_ack");
    bus_stop();
    chk("w1_busy_after_stop", {31'd0, busy}, 0);
    chk("w1_wr_drained", wr_q.size(), 0);
    host_check(4'd4, 8'h5A, "w1_reg4");
    host_check(4'd3, 8'hA5, "w1_reg3");

    // regs[5]=77 so the final read pointer is visible later
    bus_start();
    wr_acked(8'hA2, "w2_addr_ack");
    wr_acked(8'h05, "w2_ptr_ack");
    wr_q.push_back('{4'd5, 8'h77});
    wr_acked(8'h77, "w2_d0_ack");
    bus_stop();

    // combined read: ptr 03, repeated START, 51 R, ACK then NACK
    bus_start();
    wr_acked(8'hA2, "r1_addr_ack");
    wr_acked(8'h03, "r1_ptr_ack");
    bus_start();
    wr_acked(8'hA3, "r1_raddr_ack");
    rd_q.push_back(8'hA5);
    rd_check(1'b0, "r1_byte0");
    rd_q.push_back(8'h5A);
    rd_check(1'b1, "r1_byte1");
    chk("r1_busy_before_stop", {31'd0, busy}, 1);
    bus_stop();
    chk("r1_busy_after_stop", {31'd0, busy}, 0);

    // pointer left at 5
    bus_start();
    wr_acked(8'hA3, "r2_addr_ack");
    rd_q.push_back(8'h77);
    rd_check(1'b1, "r2_ptr5_byte");
    bus_stop();

    // wrong address 52 W 00 FF
    bus_start();
    wbyte(8'hA4, a);
    chk("bad_addr_nack", {31'd0, a}, 1);
    chk("bad_addr_busy", {31'd0, busy}, 0);
    wbyte(8'h00, a);
    chk("bad_addr_d0_nack", {31'd0, a}, 1);
    wbyte(8'hFF, a);
    bus_stop();
    chk("bad_addr_busy_end", {31'd0, busy}, 0);
    host_check(4'd0, 8'h00, "bad_addr_reg0");
    host_check(4'd3, 8'hA5, "bad_addr_reg3");

    // pointer wrap 15 -> 0
    bus_start();
    wr_acked(8'hA2, "wrap_addr_ack");
    wr_acked(8'h0F, "wrap_ptr_ack");
    wr_q.push_back('{4'd15, 8'h11});
    wr_acked(8'h11, "wrap_d0_ack");
    wr_q.push_back('{4'd0, 8'h22});
    wr_acked(8'h22, "wrap_d1_ack");
    bus_stop();
    chk("wrap_wr_drained", wr_q.size(), 0);
    host_check(4'd15, 8'h11, "wrap_reg15");
    host_check(4'd0, 8'h22, "wrap_reg0");

    // reset while driving read data 0 (ptr=1, regs[1]=00)
    bus_start();
    wr_acked(8'hA3, "rst_rd_addr_ack");
    clk(6);
    chk("rst_rd_drive_low", {31'd0, sdaOut}, 0);
    reset = 1'b1;
    clk(1);
    chk("rst_rd_release", {31'd0, sdaOut}, 1);
    chk("rst_rd_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    host_check(4'd3, 8'h00, "rst_rd_reg3_cleared");
    clk(4);
    bus_start();
    wr_acked(8'hA3, "rst_rd2_addr_ack");
    rd_q.push_back(8'h00);
    rd_check(1'b1, "rst_rd2_byte");
    bus_stop();

    // STOP after 4 bits of a pointer byte, then a normal write
    bus_start();
    wr_acked(8'hA2, "mid_addr_ack");
    for (int i = 0; i < 4; i++) send_bit(1'b0, a);
    bus_stop();
    chk("mid_busy", {31'd0, busy}, 0);
    bus_start();
    wr_acked(8'hA2, "mid2_addr_ack");
    wr_acked(8'h02, "mid2_ptr_ack");
    wr_q.push_back('{4'd2, 8'h3C});
    wr_acked(8'h3C, "mid2_d0_ack");
    bus_stop();
    clk(4);
    chk("final_wr_drained", wr_q.size(), 0);
    host_check(4'd2, 8'h3C, "mid2_reg2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
